// File: rtl/step_player_pkg.sv
// step_player_pkg: shared sizes and index types for the step player
package step_player_pkg;
  localparam int NUM_STEPS = 8;
  localparam int NUM_INST = 8;
  localparam logic [7:0] SEQ_HOME = 8'h80;
  typedef logic [2:0] step_t;
  typedef logic [2:0] inst_t;
endpackage

// File: rtl/onehot_enc.sv
// onehot_enc: encodes a one-hot step position into a binary index and flags whether it is truly one-hot
module onehot_enc
  import step_player_pkg::*;
(
  input  logic [7:0] onehot_i,
  output step_t      idx_o,
  output logic       valid_o
);
  // binary encode; only meaningful when valid_o is high
  always_comb begin
    idx_o = '0;
    for (int i = 0; i < NUM_STEPS; i++) if (onehot_i[i]) idx_o = step_t'(i);
  end
  assign valid_o = (onehot_i != '0) && ((onehot_i & (onehot_i - 8'd1)) == '0);
endmodule

// File: rtl/step_player.sv
// step_player: 8x8 drum pattern player; optional per-instrument hit masking with STEP_PLAYER_MUTE_EN
module step_player
  import step_player_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       srst,
  input  logic [7:0] seq_in,
  input  logic       play,
  input  logic       edit_toggle,
  input  inst_t      edit_inst,
  input  step_t      edit_step,
  input  logic       clear_pat,
`ifdef STEP_PLAYER_MUTE_EN
  input  logic [7:0] mute,
`endif
  output logic [7:0] hit,
  output step_t      step_idx,
  output logic       step_valid,
  output logic [7:0] col_out,
  output logic       err
);
  logic [NUM_STEPS-1:0][NUM_INST-1:0] pat_q, pat_d;
  logic [7:0] seq_q, hit_q, hit_d, col_q, mute_mask;
  step_t idx_q, idx_d, enc_idx;
  logic valid_q, err_q, enc_valid, step_chg;
  onehot_enc u_enc (.onehot_i(seq_in), .idx_o(enc_idx), .valid_o(enc_valid));
`ifdef STEP_PLAYER_MUTE_EN
  assign mute_mask = mute;
`else
  assign mute_mask = '0;
`endif
  assign step_chg = seq_in != seq_q;
  assign hit_d = (step_chg && enc_valid && play) ? pat_q[enc_idx] & ~mute_mask : '0;
  assign idx_d = (step_chg && enc_valid) ? enc_idx : idx_q;
  // clear beats edit; the hit path reads pat_q so it always sees the pre-edit column
  always_comb begin
    pat_d = pat_q;
    if (clear_pat) pat_d = '0;
    else if (edit_toggle) pat_d[edit_step][edit_inst] = ~pat_q[edit_step][edit_inst];
  end
  // step tracking, hit pulse and sticky error
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seq_q <= SEQ_HOME;
      hit_q <= '0;
      idx_q <= '1;
      valid_q <= 1'b1;
      err_q <= 1'b0;
    end else if (srst) begin
      seq_q <= SEQ_HOME;
      hit_q <= '0;
      idx_q <= '1;
      valid_q <= 1'b1;
      err_q <= 1'b0;
    end else begin
      seq_q <= seq_in;
      hit_q <= hit_d;
      idx_q <= idx_d;
      valid_q <= enc_valid;
      err_q <= err_q | ~enc_valid;
    end
  end
  // pattern memory survives srst
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pat_q <= '0;
    else if (!srst) pat_q <= pat_d;
  end
  // display column lags the stored pattern by one cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) col_q <= '0;
    else col_q <= pat_q[idx_q];
  end
  assign hit = hit_q;
  assign step_idx = idx_q;
  assign step_valid = valid_q;
  assign col_out = col_q;
  assign err = err_q;
endmodule

// File: tb/tb_step_player.sv
// tb_step_player: random and directed checks of step_player against a behavioural pattern model
module tb_step_player;
  logic clk = 1'b0, rst_n = 1'b0, srst = 1'b0, play = 1'b0, edit_toggle = 1'b0, clear_pat = 1'b0;
  logic [7:0] seq_in = 8'h80;
  logic [2:0] edit_inst = '0, edit_step = '0;
  logic [7:0] hit, col_out;
  logic [2:0] step_idx;
  logic step_valid, err;
`ifdef STEP_PLAYER_MUTE_EN
  logic [7:0] mute = '0;
`endif
  int total = 0, bad = 0;
  logic [7:0] m_pat [8];
  logic [7:0] m_seq, m_hit, m_col;
  logic [2:0] m_idx;
  logic m_valid, m_err;
  always #5 clk = ~clk;
  step_player dut (
    .clk(clk), .rst_n(rst_n), .srst(srst), .seq_in(seq_in), .play(play),
    .edit_toggle(edit_toggle), .edit_inst(edit_inst), .edit_step(edit_step), .clear_pat(clear_pat),
`ifdef STEP_PLAYER_MUTE_EN
    .mute(mute),
`endif
    .hit(hit), .step_idx(step_idx), .step_valid(step_valid), .col_out(col_out), .err(err)
  );
  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask
  task automatic model_reset();
    m_seq = 8'h80; m_hit = '0; m_idx = 3'd7; m_valid = 1'b1; m_col = '0; m_err = 1'b0;
    for (int i = 0; i < 8; i++) m_pat[i] = '0;
  endtask
  task automatic model_step();
    logic [7:0] col_n;
    logic v, chg;
    int k;
    col_n = m_pat[m_idx];
    v = $countones(seq_in) == 1;
    k = v ? $clog2(seq_in) : 0;
    chg = seq_in != m_seq;
    if (srst) begin
      m_seq = 8'h80; m_hit = '0; m_idx = 3'd7; m_valid = 1'b1; m_err = 1'b0;
    end else begin
      m_hit = (chg && v && play) ? m_pat[k] : 8'h00;
`ifdef STEP_PLAYER_MUTE_EN
      m_hit = m_hit & ~mute;
`endif
      if (chg && v) m_idx = k[2:0];
      m_valid = v;
      m_err = m_err | !v;
      m_seq = seq_in;
      if (clear_pat) for (int i = 0; i < 8; i++) m_pat[i] = '0;
      else if (edit_toggle) m_pat[edit_step][edit_inst] = ~m_pat[edit_step][edit_inst];
    end
    m_col = col_n;
  endtask
  task automatic cycle();
    model_step();
    @(posedge clk);
    #1;
    check("hit", hit, m_hit);
    check("step_idx", {5'd0, step_idx}, {5'd0, m_idx});
    check("step_valid", {7'd0, step_valid}, {7'd0, m_valid});
    check("col_out", col_out, m_col);
    check("err", {7'd0, err}, {7'd0, m_err});
  endtask
  task automatic toggle(input logic [2:0] inst, input logic [2:0] stp);
    edit_toggle = 1'b1; edit_inst = inst; edit_step = stp;
    cycle();
    edit_toggle = 1'b0;
  endtask
  initial begin
    model_reset();
    #12;
    check("rst_hit", hit, 8'h00);
    check("rst_idx", {5'd0, step_idx}, 8'd7);
    check("rst_valid", {7'd0, step_valid}, 8'd1);
    check("rst_col", col_out, 8'h00);
    check("rst_err", {7'd0, err}, 8'd0);
    rst_n = 1'b1;
    cycle();
    check("first_edge_hit", hit, 8'h00);
    toggle(3'd2, 3'd0);
    toggle(3'd5, 3'd0);
    play = 1'b1; seq_in = 8'h01;
    cycle();
    check("play_hit", hit, 8'h24);
    check("play_idx", {5'd0, step_idx}, 8'd0);
    cycle();
    check("hit_one_cycle", hit, 8'h00);
    check("col_step0", col_out, 8'h24);
    play = 1'b0; seq_in = 8'h80;
    cycle();
    seq_in = 8'h01;
    cycle();
    check("stop_hit", hit, 8'h00);
    check("stop_idx", {5'd0, step_idx}, 8'd0);
    cycle();
    check("stop_col", col_out, 8'h24);
    seq_in = 8'h03;
    cycle();
    check("inv_valid", {7'd0, step_valid}, 8'd0);
    check("inv_err", {7'd0, err}, 8'd1);
    check("inv_idx", {5'd0, step_idx}, 8'd0);
    seq_in = 8'h04;
    cycle();
    check("recov_idx", {5'd0, step_idx}, 8'd2);
    check("recov_err", {7'd0, err}, 8'd1);
    toggle(3'd0, 3'd3);
    play = 1'b1; seq_in = 8'h08;
    toggle(3'd0, 3'd3);
    check("edit_same_hit", hit, 8'h01);
    cycle();
    check("edit_col", col_out, 8'h00);
    srst = 1'b1;
    cycle();
    srst = 1'b0;
    check("srst_idx", {5'd0, step_idx}, 8'd7);
    check("srst_err", {7'd0, err}, 8'd0);
    seq_in = 8'h01;
    cycle();
    check("srst_keep_pat", hit, 8'h24);
    clear_pat = 1'b1;
    cycle();
    clear_pat = 1'b0;
    cycle();
    check("clear_col", col_out, 8'h00);
    for (int n = 0; n < 1500; n++) begin
      int r;
      r = int'($urandom_range(0, 9));
      seq_in = (r == 0) ? 8'($urandom) : (r < 3) ? seq_in : 8'h01 << $urandom_range(0, 7);
      play = $urandom_range(0, 3) != 0;
      edit_toggle = $urandom_range(0, 2) == 0;
      edit_inst = 3'($urandom);
      edit_step = 3'($urandom);
      clear_pat = $urandom_range(0, 60) == 0;
      srst = $urandom_range(0, 50) == 0;
`ifdef STEP_PLAYER_MUTE_EN
      mute = 8'($urandom);
`endif
      cycle();
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
